uart_imem_loader: RTL

- Boot-time writer for the processor's instruction-memory load port. Drives insMemEn/insMemAddr/insMemDataIn.
- Receives a program image over a UART 8N1 serial line and writes it to instruction memory one word at a time.
- Holds the processor in reset while loading and releases it when the image is complete.
- Sits between the board RX pin and the processor.

---
 rtl/uart_imem_loader_pkg.sv | 26 ++
 rtl/uart_rx_byte.sv | 115 +++++++++++
 rtl/uart_imem_loader.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_imem_loader_pkg.sv
// Shared definitions for the UART instruction-memory loader.
//   state_t    : loader FSM encoding (also exported on the debug port)
//   rx_state_t : UART byte receiver FSM encoding
//   HDR_BYTE   : image header byte
//   LEN_W      : width of the little-endian word-count field
package uart_imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam int         LEN_W    = 16;

endpackage

// File: rtl/uart_rx_byte.sv
// UART 8N1 byte receiver.
//   clock, reset : system clock, asynchronous active-high reset
//   rx           : serial input, idle high, asynchronous to clock
//   byteValid    : one-cycle pulse, byteData holds the received byte
//   byteData     : last received byte (LSB received first)
//   stopErr      : one-cycle pulse when the stop bit sampled low
//
// Handshake: byteValid/stopErr are single-cycle pulses with no ready;
// the consumer must take byteData in the cycle byteValid is high.
module uart_rx_byte
    import uart_imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic       byteValid,
    output logic [7:0] byteData,
    output logic       stopErr
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic            sync1_q, sync2_q, prev_q;
    rx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                // Falling edge of the synchronized line marks a start bit.
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // Line back high at mid start bit: treat as a glitch.
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    valid_d = sync2_q;
                    err_d   = !sync2_q;
                    state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byteValid = valid_q;
    assign byteData  = shift_q;
    assign stopErr   = err_q;

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: receives a program image over UART and writes it into
// instruction memory, holding the processor in reset until it is complete.
// Image: 0xA5, word count N (16-bit LE), N words of 4 bytes LE.
//   clock, reset  : system clock, asynchronous active-high reset
//   rx            : UART serial input
//   insMemEn      : one-cycle instruction-memory write strobe
//   insMemAddr    : word index of the write (zero-extended)
//   insMemDataIn  : word being written
//   cpuReset      : high holds the processor in reset (low only in DONE)
//   loadDone      : high while a complete image is resident
//   frameErr      : one-cycle pulse on bad stop bit or bad header
//   dbgState      : current loader FSM state
module uart_imem_loader
    import uart_imem_loader_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int IMEM_DEPTH   = 512,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rx,
    output logic             insMemEn,
    output logic [WIDTH-1:0] insMemAddr,
    output logic [WIDTH-1:0] insMemDataIn,
    output logic             cpuReset,
    output logic             loadDone,
    output logic             frameErr,
    output state_t           dbgState
);

    localparam int BCW = (WIDTH / 8 > 1) ? $clog2(WIDTH / 8) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(WIDTH / 8 - 1);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       stop_err;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clock    (clock),
        .reset    (reset),
        .rx       (rx),
        .byteValid(byte_valid),
        .byteData (byte_data),
        .stopErr  (stop_err)
    );

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   word_idx_q, word_idx_d;
    logic [BCW-1:0]     byte_cnt_q, byte_cnt_d;
    logic [WIDTH-1:0]   asm_q, asm_d;
    logic               en_q, en_d;
    logic [WIDTH-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               ferr_q, ferr_d;
    logic               word_done_q, word_done_d;
    logic               in_range;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            word_idx_q  <= '0;
            byte_cnt_q  <= '0;
            asm_q       <= '0;
            en_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            ferr_q      <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_idx_q  <= word_idx_d;
            byte_cnt_q  <= byte_cnt_d;
            asm_q       <= asm_d;
            en_q        <= en_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            ferr_q      <= ferr_d;
            word_done_q <= word_done_d;
        end
    end

    assign in_range = ({{(32 - LEN_W){1'b0}}, word_idx_q} < 32'(IMEM_DEPTH));

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        byte_cnt_d  = byte_cnt_q;
        asm_d       = asm_q;
        en_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        ferr_d      = stop_err;
        word_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (byte_valid) begin
                    if (byte_data == HDR_BYTE) begin
                        state_d = ST_LEN_LO;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            ST_LEN_LO: begin
                if (byte_valid) begin
                    len_d[7:0] = byte_data;
                    state_d    = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (byte_valid) begin
                    len_d[15:8] = byte_data;
                    word_idx_d  = '0;
                    byte_cnt_d  = '0;
                    state_d     = ({byte_data, len_q[7:0]} == '0) ? ST_DONE : ST_DATA;
                end
            end
            ST_DATA: begin
                // Bytes arrive LSB first; each enters at the top and the
                // word settles into place after the last byte.
                if (byte_valid) begin
                    asm_d      = {byte_data, asm_q[WIDTH-1:8]};
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d  = '0;
                        word_done_d = 1'b1;
                        if (in_range) begin
                            en_d   = 1'b1;
                            addr_d = WIDTH'(word_idx_q);
                            data_d = {byte_data, asm_q[WIDTH-1:8]};
                        end
                    end
                end
                // Advance in the strobe cycle so DONE follows the last strobe.
                if (word_done_q) begin
                    word_idx_d = word_idx_q + 1'b1;
                    if (word_idx_q + 1'b1 == len_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (byte_valid && byte_data == HDR_BYTE) begin
                    state_d = ST_LEN_LO;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A broken frame mid-image abandons the load.
        if (stop_err && (state_q == ST_LEN_LO || state_q == ST_LEN_HI || state_q == ST_DATA)) begin
            state_d     = ST_IDLE;
            addr_d      = '0;
            byte_cnt_d  = '0;
            word_done_d = 1'b0;
        end
    end

    assign insMemEn     = en_q;
    assign insMemAddr   = addr_q;
    assign insMemDataIn = data_q;
    assign cpuReset     = (state_q != ST_DONE);
    assign loadDone     = (state_q == ST_DONE);
    assign frameErr     = ferr_q;
    assign dbgState     = state_q;

endmodule
